datamem_ctrl: RTL and testbench

Parametrised single-port synchronous data memory with a request/ready handshake, configurable read latency, selectable write-through behaviour and a hardware clear sweep. It replaces the fixed 8×256 data memory in the processor datapath. The load/store stage drives it directly, and it needs no initial-block preload for zeroed memory.

---
 rtl/datamem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_datamem_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_ctrl.sv
// datamem_ctrl
// Single-port synchronous data memory for the load/store stage. A request is
// taken on a rising edge where Req and Ready are both high. The read latency
// can be set to 1 or 2 cycles. Writes can optionally appear on DataOut at once
// (write-through). A hardware sweep zeroes every word after reset, or whenever
// ClearReq is pulsed, so the memory needs no preload.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high reset
//   Req       - request valid
//   MemWrite  - 1 = write, 0 = read (only meaningful while Req is high)
//   DataAddr  - word address (addresses >= DEPTH are out of range)
//   DataIn    - write data
//   ClearReq  - single-cycle pulse that starts a clear sweep
//   Ready     - registered; high when a request can be accepted this cycle
//   DataOut   - read data (or write-through data); holds between updates
//   DataValid - one-cycle pulse marking new read data on DataOut
//
// RD_LAT values other than 2 behave as RD_LAT=1.

module datamem_ctrl #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter int WRITE_THROUGH  = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Req,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataIn,
  input  logic          ClearReq,
  output logic          Ready,
  output logic [DW-1:0] DataOut,
  output logic          DataValid
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  localparam int          LAST_INT    = DEPTH - 1;
  localparam logic [AW-1:0] LAST_ADDR = LAST_INT[AW-1:0];
  // DEPTH may equal 2**AW, so the range compare is done one bit wider.
  localparam logic [AW:0] DEPTH_EXT   = DEPTH[AW:0];
  localparam state_t      RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic        RESET_READY = (CLEAR_ON_RESET == 0);

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  logic [AW-1:0] r_clrCnt;
  logic          r_ready;
  logic [DW-1:0] r_dataOut;
  logic          r_dataValid;

  logic          w_inRange;
  logic          w_accept;
  logic          w_acceptWrite;
  logic          w_acceptRead;
  logic          w_clearWe;
  logic [DW-1:0] w_rdData;
  logic          w_finalValid;
  logic [DW-1:0] w_finalData;

  assign w_inRange     = ({1'b0, DataAddr} < DEPTH_EXT);
  assign w_accept      = Req && r_ready;
  // Out-of-range writes are dropped entirely, including write-through.
  assign w_acceptWrite = w_accept && MemWrite && w_inRange;
  // Every accepted read produces a DataValid pulse; out-of-range reads give zero.
  assign w_acceptRead  = w_accept && !MemWrite;
  assign w_rdData      = w_inRange ? r_mem[DataAddr] : '0;
  // The sweep writes while in CLEAR. Edges seen while reset is held only rewrite
  // address 0 with zero, which the following sweep zeroes anyway.
  assign w_clearWe     = (r_state == ST_CLEAR);

  // Control FSM. Ready is registered next to the state so it always equals
  // (state == READY). A ClearReq in READY resets the sweep counter. A request
  // accepted on the same edge is still performed, because the accept decision
  // uses the current Ready. ClearReq during CLEAR is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RESET_STATE;
      r_clrCnt <= '0;
      r_ready  <= RESET_READY;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clrCnt == LAST_ADDR) begin
            r_state  <= ST_READY;
            r_ready  <= 1'b1;
            r_clrCnt <= '0;
          end else begin
            r_clrCnt <= r_clrCnt + 1'b1;
          end
        end
        ST_READY: begin
          if (ClearReq) begin
            r_state  <= ST_CLEAR;
            r_ready  <= 1'b0;
            r_clrCnt <= '0;
          end
        end
        default: begin
          r_state  <= RESET_STATE;
          r_ready  <= RESET_READY;
          r_clrCnt <= '0;
        end
      endcase
    end
  end

  // Storage array. It has no reset so that reset alone leaves the contents
  // intact. Sweep writes and request writes never coincide, because requests
  // are only accepted in READY.
  always_ff @(posedge clk) begin
    if (w_clearWe) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_acceptWrite) begin
      r_mem[DataAddr] <= DataIn;
    end
  end

  // Read pipeline. The data is captured at the accept edge. As a result, a read
  // still in flight when a sweep starts completes with the old contents.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          r_pipeValid;
      logic [DW-1:0] r_pipeData;

      // One extra register stage. Reset discards a read in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pipeValid <= 1'b0;
          r_pipeData  <= '0;
        end else begin
          r_pipeValid <= w_acceptRead;
          r_pipeData  <= w_rdData;
        end
      end

      assign w_finalValid = r_pipeValid;
      assign w_finalData  = r_pipeData;
    end else begin : g_lat1
      assign w_finalValid = w_acceptRead;
      assign w_finalData  = w_rdData;
    end
  endgenerate

  // Output register. A completing read takes priority over write-through data.
  // Otherwise DataOut holds its value, so it is stable while DataValid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
    end else if (w_finalValid) begin
      r_dataOut   <= w_finalData;
      r_dataValid <= 1'b1;
    end else begin
      r_dataValid <= 1'b0;
      if ((WRITE_THROUGH != 0) && w_acceptWrite) begin
        r_dataOut <= DataIn;
      end
    end
  end

  assign Ready     = r_ready;
  assign DataOut   = r_dataOut;
  assign DataValid = r_dataValid;

endmodule

// File: tb/tb_datamem_ctrl.sv
// tb_datamem_ctrl
// Directed bench for datamem_ctrl. Three instances share clock, reset and
// request inputs:
//   A: DEPTH=256, RD_LAT=2, no write-through, clear on reset
//   B: DEPTH=256, RD_LAT=1, write-through,    clear on reset
//   C: DEPTH=200, RD_LAT=2, write-through,    no clear on reset
// Inputs change 1ns after a rising edge, and outputs are sampled at that same point.

module tb_datamem_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic       memWrite;
  logic [7:0] dataAddr;
  logic [7:0] dataIn;
  logic       clearReq;

  logic       rdyA, vA;
  logic [7:0] outA;
  logic       rdyB, vB;
  logic [7:0] outB;
  logic       rdyC, vC;
  logic [7:0] outC;

  int checks;
  int fails;

  datamem_ctrl #(.DW(8), .AW(8), .DEPTH(256), .RD_LAT(2), .WRITE_THROUGH(0), .CLEAR_ON_RESET(1)) dutA (
    .clk(clk), .reset(reset), .Req(req), .MemWrite(memWrite), .DataAddr(dataAddr),
    .DataIn(dataIn), .ClearReq(clearReq), .Ready(rdyA), .DataOut(outA), .DataValid(vA));

  datamem_ctrl #(.DW(8), .AW(8), .DEPTH(256), .RD_LAT(1), .WRITE_THROUGH(1), .CLEAR_ON_RESET(1)) dutB (
    .clk(clk), .reset(reset), .Req(req), .MemWrite(memWrite), .DataAddr(dataAddr),
    .DataIn(dataIn), .ClearReq(clearReq), .Ready(rdyB), .DataOut(outB), .DataValid(vB));

  datamem_ctrl #(.DW(8), .AW(8), .DEPTH(200), .RD_LAT(2), .WRITE_THROUGH(1), .CLEAR_ON_RESET(0)) dutC (
    .clk(clk), .reset(reset), .Req(req), .MemWrite(memWrite), .DataAddr(dataAddr),
    .DataIn(dataIn), .ClearReq(clearReq), .Ready(rdyC), .DataOut(outC), .DataValid(vC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset values, then count the sweep length after release.
  task automatic test_reset;
    int cnt;
    reset = 1'b1; req = 1'b0; memWrite = 1'b0; dataAddr = 8'h00; dataIn = 8'h00; clearReq = 1'b0;
    tick;
    tick;
    checks++; if (rdyA !== 1'b0) begin fails++; $display("[TB] FAIL reset_readyA: got %b expected 0", rdyA); end
    checks++; if (outA !== 8'h00) begin fails++; $display("[TB] FAIL reset_outA: got %h expected 00", outA); end
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL reset_validA: got %b expected 0", vA); end
    checks++; if (rdyC !== 1'b1) begin fails++; $display("[TB] FAIL reset_readyC: got %b expected 1", rdyC); end
    checks++; if (outC !== 8'h00) begin fails++; $display("[TB] FAIL reset_outC: got %h expected 00", outC); end
    reset = 1'b0;
    cnt = 0;
    while (rdyA !== 1'b1 && cnt < 1000) begin
      tick;
      cnt++;
    end
    checks++; if (cnt !== 256) begin fails++; $display("[TB] FAIL reset_sweep_len: got %0d expected 256", cnt); end
    checks++; if (rdyB !== 1'b1) begin fails++; $display("[TB] FAIL reset_readyB: got %b expected 1", rdyB); end
  endtask

  // A freshly swept memory reads zero, with exactly one DataValid per read.
  task automatic test_read_zero;
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; memWrite = 1'b0; dataAddr = addrs[i];
      tick;
      checks++; if (vB !== 1'b1 || outB !== 8'h00) begin fails++; $display("[TB] FAIL zero_rdB addr %0d: got v=%b d=%h expected v=1 d=00", addrs[i], vB, outB); end
      checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL zero_earlyA addr %0d: got v=%b expected 0", addrs[i], vA); end
      req = 1'b0;
      tick;
      checks++; if (vA !== 1'b1 || outA !== 8'h00) begin fails++; $display("[TB] FAIL zero_rdA addr %0d: got v=%b d=%h expected v=1 d=00", addrs[i], vA, outA); end
      checks++; if (vB !== 1'b0) begin fails++; $display("[TB] FAIL zero_pulseB addr %0d: got v=%b expected 0", addrs[i], vB); end
    end
    // Address 255 is out of range for C and reads as zero.
    checks++; if (vC !== 1'b1 || outC !== 8'h00) begin fails++; $display("[TB] FAIL zero_oobC: got v=%b d=%h expected v=1 d=00", vC, outC); end
  endtask

  // Two writes, then two back-to-back reads.
  task automatic test_back_to_back;
    req = 1'b1; memWrite = 1'b1; dataAddr = 8'd0; dataIn = 8'h3C;
    tick;
    checks++; if (outB !== 8'h3C || vB !== 1'b0) begin fails++; $display("[TB] FAIL b2b_wtB0: got v=%b d=%h expected v=0 d=3c", vB, outB); end
    checks++; if (outA !== 8'h00) begin fails++; $display("[TB] FAIL b2b_holdA: got %h expected 00", outA); end
    dataAddr = 8'd1; dataIn = 8'h74;
    tick;
    checks++; if (outB !== 8'h74) begin fails++; $display("[TB] FAIL b2b_wtB1: got %h expected 74", outB); end
    memWrite = 1'b0; dataAddr = 8'd0;
    tick;
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL b2b_latA: got v=%b expected 0", vA); end
    checks++; if (vB !== 1'b1 || outB !== 8'h3C) begin fails++; $display("[TB] FAIL b2b_rdB0: got v=%b d=%h expected v=1 d=3c", vB, outB); end
    dataAddr = 8'd1;
    tick;
    checks++; if (vA !== 1'b1 || outA !== 8'h3C) begin fails++; $display("[TB] FAIL b2b_rdA0: got v=%b d=%h expected v=1 d=3c", vA, outA); end
    checks++; if (vB !== 1'b1 || outB !== 8'h74) begin fails++; $display("[TB] FAIL b2b_rdB1: got v=%b d=%h expected v=1 d=74", vB, outB); end
    req = 1'b0;
    tick;
    checks++; if (vA !== 1'b1 || outA !== 8'h74) begin fails++; $display("[TB] FAIL b2b_rdA1: got v=%b d=%h expected v=1 d=74", vA, outA); end
    checks++; if (vC !== 1'b1 || outC !== 8'h74) begin fails++; $display("[TB] FAIL b2b_rdC1: got v=%b d=%h expected v=1 d=74", vC, outC); end
    checks++; if (vB !== 1'b0 || outB !== 8'h74) begin fails++; $display("[TB] FAIL b2b_holdB: got v=%b d=%h expected v=0 d=74", vB, outB); end
    tick;
    checks++; if (vA !== 1'b0 || outA !== 8'h74) begin fails++; $display("[TB] FAIL b2b_endA: got v=%b d=%h expected v=0 d=74", vA, outA); end
  endtask

  // Read-after-write on the very next cycle.
  task automatic test_raw;
    req = 1'b1; memWrite = 1'b1; dataAddr = 8'd7; dataIn = 8'hA5;
    tick;
    checks++; if (outB !== 8'hA5 || vB !== 1'b0) begin fails++; $display("[TB] FAIL raw_wtB: got v=%b d=%h expected v=0 d=a5", vB, outB); end
    checks++; if (outA !== 8'h74) begin fails++; $display("[TB] FAIL raw_holdA: got %h expected 74", outA); end
    memWrite = 1'b0;
    tick;
    checks++; if (vB !== 1'b1 || outB !== 8'hA5) begin fails++; $display("[TB] FAIL raw_rdB: got v=%b d=%h expected v=1 d=a5", vB, outB); end
    req = 1'b0;
    tick;
    checks++; if (vA !== 1'b1 || outA !== 8'hA5) begin fails++; $display("[TB] FAIL raw_rdA: got v=%b d=%h expected v=1 d=a5", vA, outA); end
    checks++; if (vB !== 1'b0 || outB !== 8'hA5) begin fails++; $display("[TB] FAIL raw_holdB: got v=%b d=%h expected v=0 d=a5", vB, outB); end
  endtask

  // On C, a completing read beats write-through data at the same edge.
  task automatic test_wt_priority;
    req = 1'b1; memWrite = 1'b0; dataAddr = 8'd7;
    tick;
    memWrite = 1'b1; dataAddr = 8'd8; dataIn = 8'h5A;
    tick;
    checks++; if (vC !== 1'b1 || outC !== 8'hA5) begin fails++; $display("[TB] FAIL prio_C: got v=%b d=%h expected v=1 d=a5", vC, outC); end
    checks++; if (vB !== 1'b0 || outB !== 8'h5A) begin fails++; $display("[TB] FAIL prio_wtB: got v=%b d=%h expected v=0 d=5a", vB, outB); end
    checks++; if (vA !== 1'b1 || outA !== 8'hA5) begin fails++; $display("[TB] FAIL prio_A: got v=%b d=%h expected v=1 d=a5", vA, outA); end
    req = 1'b0;
    tick;
    checks++; if (vC !== 1'b0 || outC !== 8'hA5) begin fails++; $display("[TB] FAIL prio_holdC: got v=%b d=%h expected v=0 d=a5", vC, outC); end
  endtask

  // Out-of-range write and read on C (DEPTH=200). The same address is in range for A and B.
  task automatic test_out_of_range;
    req = 1'b1; memWrite = 1'b1; dataAddr = 8'd10; dataIn = 8'h10;
    tick;
    dataAddr = 8'd210; dataIn = 8'hFF;
    tick;
    checks++; if (outC !== 8'h10 || vC !== 1'b0) begin fails++; $display("[TB] FAIL oob_wtC: got v=%b d=%h expected v=0 d=10", vC, outC); end
    checks++; if (outB !== 8'hFF) begin fails++; $display("[TB] FAIL oob_wtB: got %h expected ff", outB); end
    memWrite = 1'b0;
    tick;
    req = 1'b0;
    tick;
    checks++; if (vC !== 1'b1 || outC !== 8'h00) begin fails++; $display("[TB] FAIL oob_rdC: got v=%b d=%h expected v=1 d=00", vC, outC); end
    checks++; if (vA !== 1'b1 || outA !== 8'hFF) begin fails++; $display("[TB] FAIL oob_rdA: got v=%b d=%h expected v=1 d=ff", vA, outA); end
    req = 1'b1; dataAddr = 8'd10;
    tick;
    req = 1'b0;
    tick;
    checks++; if (vC !== 1'b1 || outC !== 8'h10) begin fails++; $display("[TB] FAIL oob_aliasC: got v=%b d=%h expected v=1 d=10", vC, outC); end
  endtask

  // A read accepted together with ClearReq keeps its old data. The sweep
  // length is checked, and a ClearReq during the sweep must not restart it.
  task automatic test_clear_with_read;
    int lowA;
    int lowC;
    lowA = 0; lowC = 0;
    req = 1'b1; memWrite = 1'b0; dataAddr = 8'd1; clearReq = 1'b1;
    tick;
    if (rdyA !== 1'b1) lowA++;
    if (rdyC !== 1'b1) lowC++;
    checks++; if (rdyA !== 1'b0) begin fails++; $display("[TB] FAIL clr_readyA: got %b expected 0", rdyA); end
    checks++; if (vB !== 1'b1 || outB !== 8'h74) begin fails++; $display("[TB] FAIL clr_rdB: got v=%b d=%h expected v=1 d=74", vB, outB); end
    req = 1'b0; clearReq = 1'b0;
    tick;
    if (rdyA !== 1'b1) lowA++;
    if (rdyC !== 1'b1) lowC++;
    checks++; if (vA !== 1'b1 || outA !== 8'h74) begin fails++; $display("[TB] FAIL clr_rdA: got v=%b d=%h expected v=1 d=74", vA, outA); end
    checks++; if (vC !== 1'b1 || outC !== 8'h74) begin fails++; $display("[TB] FAIL clr_rdC: got v=%b d=%h expected v=1 d=74", vC, outC); end
    for (int i = 0; i < 298; i++) begin
      clearReq = (i == 50);
      tick;
      if (rdyA !== 1'b1) lowA++;
      if (rdyC !== 1'b1) lowC++;
    end
    clearReq = 1'b0;
    checks++; if (lowA !== 256) begin fails++; $display("[TB] FAIL clr_lenA: got %0d expected 256", lowA); end
    checks++; if (lowC !== 200) begin fails++; $display("[TB] FAIL clr_lenC: got %0d expected 200", lowC); end
    checks++; if (rdyB !== 1'b1) begin fails++; $display("[TB] FAIL clr_readyB: got %b expected 1", rdyB); end
    req = 1'b1; dataAddr = 8'd1;
    tick;
    checks++; if (vB !== 1'b1 || outB !== 8'h00) begin fails++; $display("[TB] FAIL clr_zeroB: got v=%b d=%h expected v=1 d=00", vB, outB); end
    req = 1'b0;
    tick;
    checks++; if (vA !== 1'b1 || outA !== 8'h00) begin fails++; $display("[TB] FAIL clr_zeroA: got v=%b d=%h expected v=1 d=00", vA, outA); end
    checks++; if (vC !== 1'b1 || outC !== 8'h00) begin fails++; $display("[TB] FAIL clr_zeroC: got v=%b d=%h expected v=1 d=00", vC, outC); end
  endtask

  // Reset asserted in the middle of a sweep: the outputs clear at once and the sweep restarts from 0.
  task automatic test_reset_mid_sweep;
    int cnt;
    req = 1'b1; memWrite = 1'b1; dataAddr = 8'd3; dataIn = 8'h42;
    tick;
    memWrite = 1'b0;
    tick;
    req = 1'b0;
    tick;
    checks++; if (outA !== 8'h42) begin fails++; $display("[TB] FAIL mid_preA: got %h expected 42", outA); end
    clearReq = 1'b1;
    tick;
    clearReq = 1'b0;
    repeat (100) tick;
    reset = 1'b1;
    #1;
    checks++; if (outA !== 8'h00 || vA !== 1'b0) begin fails++; $display("[TB] FAIL mid_outA: got v=%b d=%h expected v=0 d=00", vA, outA); end
    checks++; if (outB !== 8'h00) begin fails++; $display("[TB] FAIL mid_outB: got %h expected 00", outB); end
    checks++; if (rdyA !== 1'b0) begin fails++; $display("[TB] FAIL mid_readyA: got %b expected 0", rdyA); end
    checks++; if (rdyC !== 1'b1) begin fails++; $display("[TB] FAIL mid_readyC: got %b expected 1", rdyC); end
    tick;
    tick;
    reset = 1'b0;
    cnt = 0;
    while (rdyA !== 1'b1 && cnt < 1000) begin
      tick;
      cnt++;
    end
    checks++; if (cnt !== 256) begin fails++; $display("[TB] FAIL mid_restart_len: got %0d expected 256", cnt); end
  endtask

  // Reset asserted while a RD_LAT=2 read is in flight: no late pulse may appear.
  task automatic test_reset_inflight;
    req = 1'b1; memWrite = 1'b1; dataAddr = 8'd4; dataIn = 8'h99;
    tick;
    memWrite = 1'b0;
    tick;
    req = 1'b0;
    tick;
    checks++; if (vA !== 1'b1 || outA !== 8'h99) begin fails++; $display("[TB] FAIL fly_preA: got v=%b d=%h expected v=1 d=99", vA, outA); end
    req = 1'b1;
    tick;
    req = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (outA !== 8'h00 || vA !== 1'b0) begin fails++; $display("[TB] FAIL fly_outA: got v=%b d=%h expected v=0 d=00", vA, outA); end
    checks++; if (outB !== 8'h00 || vB !== 1'b0) begin fails++; $display("[TB] FAIL fly_outB: got v=%b d=%h expected v=0 d=00", vB, outB); end
    tick;
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL fly_lateA_rst: got %b expected 0", vA); end
    reset = 1'b0;
    tick;
    checks++; if (vA !== 1'b0 || outA !== 8'h00) begin fails++; $display("[TB] FAIL fly_lateA: got v=%b d=%h expected v=0 d=00", vA, outA); end
    tick;
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL fly_lateA2: got %b expected 0", vA); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_read_zero;
    test_back_to_back;
    test_raw;
    test_wt_priority;
    test_out_of_range;
    test_clear_with_read;
    test_reset_mid_sweep;
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
